// File: rtl/mapper_pkg.sv
// ----------------------------------------------------------------------------
// mapper_pkg
// Shared definitions for the MegaMapper virtualization trap logic.
//   state_t          : trap sequencer FSM encoding (also exported on o_state)
//   NMI_LEN_DEFAULT  : clocks the NMI line is held low per trap
//   ACK_MAX_DEFAULT  : clocks to wait for the NMI acknowledge fetch
//   EXIT_PORT_*      : mapper low-address match for the trap-exit port (3'b11x)
//   is_guest()       : states in which the CPU is still running guest code
// ----------------------------------------------------------------------------
package mapper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_VIRT = 3'd2,
    ST_CAPT = 3'd3,
    ST_NMI  = 3'd4,
    ST_ACK  = 3'd5,
    ST_TRAP = 3'd6
  } state_t;

  localparam int NMI_LEN_DEFAULT = 4;
  localparam int ACK_MAX_DEFAULT = 255;

  // The exit port decodes as lo_addr = 3'b11x; the decode itself lives in the
  // mapper I/O block, which presents the result as exit_wr.
  localparam logic [2:0] EXIT_PORT_ADDR = 3'b110;
  localparam logic [2:0] EXIT_PORT_MASK = 3'b110;

  // Guest code keeps executing (translated) until the NMI acknowledge fetch,
  // so the capture/NMI/ack-wait states still count as guest mode.
  function automatic logic is_guest(input state_t s);
    return (s == ST_VIRT) || (s == ST_CAPT) || (s == ST_NMI) || (s == ST_ACK);
  endfunction

endpackage

// File: rtl/m1_fetch_detect.sv
// ----------------------------------------------------------------------------
// m1_fetch_detect
// Registered opcode-fetch detector. Emits a one-clock o_fetch_start pulse the
// clock after the first sample of M1+MREQ within an M1 cycle.
//   i_clk, i_reset          : CPU clock, asynchronous active-high reset
//   i_m1_n, i_mreq_n, i_iorq_n : Z80 strobes
//   o_fetch_start           : one-clock pulse per opcode fetch
// ----------------------------------------------------------------------------
module m1_fetch_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_m1_n,
  input  logic i_mreq_n,
  input  logic i_iorq_n,
  output logic o_fetch_start
);

  logic r_armed;
  logic r_fetch_start;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_armed       <= 1'b1;
      r_fetch_start <= 1'b0;
    end else begin
      r_fetch_start <= 1'b0;
      if (i_m1_n) begin
        r_armed <= 1'b1;
      end else if (r_armed && (!i_mreq_n || !i_iorq_n)) begin
        // An interrupt-acknowledge M1 (IORQ low) consumes the arm silently.
        r_armed       <= 1'b0;
        r_fetch_start <= !i_mreq_n && i_iorq_n;
      end
    end
  end

  assign o_fetch_start = r_fetch_start;

endmodule

// File: rtl/trap_sequencer.sv
// ----------------------------------------------------------------------------
// trap_sequencer
// Clocked controller for the MegaMapper virtualization trap sequence. Tracks
// host (trap) vs guest (virtual) execution, gates address translation, and on
// a guest I/O violation captures the address and raises an NMI.
//   i_clk, i_reset       : Z80 clock, asynchronous active-high reset
//   i_m1_n/i_mreq_n/i_iorq_n : Z80 strobes
//   i_virtual_enable     : control bit 0, low forces IDLE
//   i_force_irq          : control bit 1, drives irq_n in trap mode
//   i_irq_sys_n          : system interrupt, passed through in guest mode
//   i_io_violation       : guest touched a protected port (valid with IORQ low)
//   i_exit_wr            : level write to trap-exit port (rising edge used)
//   i_last_isr_jmp       : previous opcode was a jump
//   o_nmi_n              : registered NMI to CPU
//   o_irq_n              : maskable interrupt to CPU
//   o_trap_state         : 1 = host/trap mode
//   o_translate_addr     : registered address translation enable
//   o_capture_address    : one-clock strobe to latch the violating address
//   o_violation_flag     : sticky trap cause
//   o_state              : current FSM state
// ----------------------------------------------------------------------------
module trap_sequencer
  import mapper_pkg::*;
#(
  parameter int NMI_LEN = NMI_LEN_DEFAULT,
  parameter int ACK_MAX = ACK_MAX_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_m1_n,
  input  logic       i_mreq_n,
  input  logic       i_iorq_n,
  input  logic       i_virtual_enable,
  input  logic       i_force_irq,
  input  logic       i_irq_sys_n,
  input  logic       i_io_violation,
  input  logic       i_exit_wr,
  input  logic       i_last_isr_jmp,
  output logic       o_nmi_n,
  output logic       o_irq_n,
  output logic       o_trap_state,
  output logic       o_translate_addr,
  output logic       o_capture_address,
  output logic       o_violation_flag,
  output logic [2:0] o_state
);

  localparam int CNT_MAX = (NMI_LEN > ACK_MAX) ? NMI_LEN : ACK_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t NMI_LOAD = cnt_t'(NMI_LEN);
  localparam cnt_t ACK_LOAD = cnt_t'(ACK_MAX);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  state_t r_state, w_state_next;
  cnt_t   r_nmi_cnt, w_nmi_cnt_next;
  cnt_t   r_ack_cnt, w_ack_cnt_next;
  logic   r_nmi_n;
  logic   r_trap_state;
  logic   r_translate;
  logic   r_violation, w_violation_next;
  logic   r_exit_wr_d;
  logic   w_exit_rise;
  logic   w_fetch_start;
  logic   w_guest_next;

  m1_fetch_detect u_fetch (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_m1_n       (i_m1_n),
    .i_mreq_n     (i_mreq_n),
    .i_iorq_n     (i_iorq_n),
    .o_fetch_start(w_fetch_start)
  );

  // Only the rising edge of the level exit strobe re-arms, so a held write
  // arms exactly once.
  assign w_exit_rise = i_exit_wr && !r_exit_wr_d;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_exit_rise) w_state_next = ST_ARM;
      ST_ARM:  if (w_fetch_start && i_last_isr_jmp) w_state_next = ST_VIRT;
      ST_VIRT: if (i_io_violation && !i_iorq_n) w_state_next = ST_CAPT;
      ST_CAPT: w_state_next = ST_NMI;
      ST_NMI: begin
        if (w_fetch_start)               w_state_next = ST_TRAP;
        else if (r_nmi_cnt <= CNT_ONE)   w_state_next = ST_ACK;
      end
      ST_ACK:  if (w_fetch_start || r_ack_cnt <= CNT_ONE) w_state_next = ST_TRAP;
      ST_TRAP: if (w_exit_rise) w_state_next = ST_ARM;
      default: w_state_next = ST_IDLE;
    endcase
    // Disabling virtualization overrides everything, including a violation.
    if (!i_virtual_enable) w_state_next = ST_IDLE;

    // The NMI counter keeps running after an early ack so the pulse always
    // completes its full length; nmi_n follows it.
    w_nmi_cnt_next = (r_nmi_cnt != '0) ? r_nmi_cnt - CNT_ONE : '0;
    if (r_state == ST_CAPT && w_state_next == ST_NMI) w_nmi_cnt_next = NMI_LOAD;

    w_ack_cnt_next = (r_ack_cnt != '0) ? r_ack_cnt - CNT_ONE : '0;
    if (r_state != ST_ACK && w_state_next == ST_ACK) w_ack_cnt_next = ACK_LOAD;

    w_violation_next = r_violation;
    if (r_state == ST_CAPT) w_violation_next = 1'b1;
    if (r_state == ST_TRAP && w_state_next == ST_ARM) w_violation_next = 1'b0;

    w_guest_next = is_guest(w_state_next);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_nmi_cnt    <= '0;
      r_ack_cnt    <= '0;
      r_nmi_n      <= 1'b1;
      r_trap_state <= 1'b1;
      r_translate  <= 1'b0;
      r_violation  <= 1'b0;
      r_exit_wr_d  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_nmi_cnt    <= w_nmi_cnt_next;
      r_ack_cnt    <= w_ack_cnt_next;
      r_nmi_n      <= (w_nmi_cnt_next == '0);
      r_trap_state <= !w_guest_next;
      r_translate  <= w_guest_next;
      r_violation  <= w_violation_next;
      r_exit_wr_d  <= i_exit_wr;
    end
  end

  assign o_nmi_n           = r_nmi_n;
  assign o_irq_n           = r_trap_state ? !i_force_irq : i_irq_sys_n;
  assign o_trap_state      = r_trap_state;
  assign o_translate_addr  = r_translate;
  assign o_capture_address = (r_state == ST_CAPT);
  assign o_violation_flag  = r_violation;
  assign o_state           = r_state;

endmodule

// File: tb/tb_trap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_trap_sequencer
// Directed bench for trap_sequencer with NMI_LEN=4, ACK_MAX=255.
// ----------------------------------------------------------------------------
module tb_trap_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_n, mreq_n, iorq_n;
  logic       virtual_enable, force_irq, irq_sys_n;
  logic       io_violation, exit_wr, last_isr_jmp;
  logic       nmi_n, irq_n, trap_state, translate_addr;
  logic       capture_address, violation_flag;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int low_clks;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_m1_n           (m1_n),
    .i_mreq_n         (mreq_n),
    .i_iorq_n         (iorq_n),
    .i_virtual_enable (virtual_enable),
    .i_force_irq      (force_irq),
    .i_irq_sys_n      (irq_sys_n),
    .i_io_violation   (io_violation),
    .i_exit_wr        (exit_wr),
    .i_last_isr_jmp   (last_isr_jmp),
    .o_nmi_n          (nmi_n),
    .o_irq_n          (irq_n),
    .o_trap_state     (trap_state),
    .o_translate_addr (translate_addr),
    .o_capture_address(capture_address),
    .o_violation_flag (violation_flag),
    .o_state          (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One opcode fetch: fetch_start is high during the second clock, so the
  // FSM acts on it at the second edge.
  task automatic fetch(input logic jmp);
    last_isr_jmp = jmp;
    m1_n = 1'b0; mreq_n = 1'b0;
    step();
    m1_n = 1'b1; mreq_n = 1'b1;
    step();
  endtask

  task automatic pulse_exit();
    exit_wr = 1'b1;
    step();
    exit_wr = 1'b0;
  endtask

  task automatic violate();
    iorq_n = 1'b0; io_violation = 1'b1;
    step();
    iorq_n = 1'b1; io_violation = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog state=%0d", state);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    virtual_enable = 1'b0; force_irq = 1'b0; irq_sys_n = 1'b1;
    io_violation = 1'b0; exit_wr = 1'b0; last_isr_jmp = 1'b0;
    step(); step();

    // Reset values
    check("rst_state", 32'(state), 32'd0);
    check("rst_nmi_n", 32'(nmi_n), 32'd1);
    check("rst_trap", 32'(trap_state), 32'd1);
    check("rst_translate", 32'(translate_addr), 32'd0);
    check("rst_capture", 32'(capture_address), 32'd0);
    check("rst_flag", 32'(violation_flag), 32'd0);
    force_irq = 1'b1; #1;
    check("irq_trap_force", 32'(irq_n), 32'd0);
    force_irq = 1'b0; #1;
    check("irq_trap_noforce", 32'(irq_n), 32'd1);

    reset = 1'b0;
    step();

    // exit_wr without virtual_enable is ignored
    pulse_exit();
    check("idle_exit_ignored", 32'(state), 32'd0);
    step();

    // Enter guest mode
    virtual_enable = 1'b1;
    pulse_exit();
    check("arm_state", 32'(state), 32'd1);
    check("arm_trap", 32'(trap_state), 32'd1);
    fetch(1'b1);
    check("virt_state", 32'(state), 32'd2);
    check("virt_translate", 32'(translate_addr), 32'd1);
    check("virt_trap", 32'(trap_state), 32'd0);
    irq_sys_n = 1'b0; #1;
    check("irq_guest_pass", 32'(irq_n), 32'd0);
    irq_sys_n = 1'b1;

    // Violation flag without IORQ does not trap
    io_violation = 1'b1;
    step();
    io_violation = 1'b0;
    check("viol_no_iorq", 32'(state), 32'd2);

    // Violation -> capture strobe then NMI; ack fetch at clk 2 of the pulse
    violate();
    check("capt_state", 32'(state), 32'd3);
    check("capt_strobe", 32'(capture_address), 32'd1);
    step();
    check("nmi_state", 32'(state), 32'd4);
    check("capt_strobe_off", 32'(capture_address), 32'd0);
    check("nmi_low_1", 32'(nmi_n), 32'd0);
    check("flag_set", 32'(violation_flag), 32'd1);
    m1_n = 1'b0; mreq_n = 1'b0;
    step();
    check("nmi_low_2", 32'(nmi_n), 32'd0);
    m1_n = 1'b1; mreq_n = 1'b1;
    step();
    check("ack_trap_state", 32'(state), 32'd6);
    check("ack_translate", 32'(translate_addr), 32'd0);
    check("ack_trap", 32'(trap_state), 32'd1);
    check("nmi_low_3", 32'(nmi_n), 32'd0);
    step();
    check("nmi_low_4", 32'(nmi_n), 32'd0);
    step();
    check("nmi_released", 32'(nmi_n), 32'd1);
    pulse_exit();
    check("trap_exit_arm", 32'(state), 32'd1);
    check("flag_cleared", 32'(violation_flag), 32'd0);

    // Interrupt-acknowledge M1 and non-jump fetch do not leave ARM
    last_isr_jmp = 1'b1;
    m1_n = 1'b0; iorq_n = 1'b0;
    step(); step();
    m1_n = 1'b1; iorq_n = 1'b1;
    step();
    check("intack_no_fetch", 32'(state), 32'd1);
    fetch(1'b0);
    check("nojmp_stay_arm", 32'(state), 32'd1);
    fetch(1'b1);
    check("virt_again", 32'(state), 32'd2);

    // No ack: full 4-clock pulse, then ACK wait of 255 clocks
    violate();
    step();
    low_clks = 0;
    while (nmi_n == 1'b0 && low_clks < 20) begin
      low_clks++;
      step();
    end
    check("nmi_low_clks", 32'(low_clks), 32'd4);
    check("ack_wait_state", 32'(state), 32'd5);
    check("ack_wait_translate", 32'(translate_addr), 32'd1);
    for (int i = 0; i < 254; i++) step();
    check("ack_wait_254", 32'(state), 32'd5);
    step();
    check("ack_timeout_trap", 32'(state), 32'd6);
    check("timeout_trap", 32'(trap_state), 32'd1);
    check("timeout_flag", 32'(violation_flag), 32'd1);
    force_irq = 1'b1; #1;
    check("irq_trap_force2", 32'(irq_n), 32'd0);
    force_irq = 1'b0;
    exit_wr = 1'b1;
    step();
    check("timeout_exit_arm", 32'(state), 32'd1);
    check("timeout_flag_clr", 32'(violation_flag), 32'd0);
    step();
    exit_wr = 1'b0;
    check("held_exit_arm", 32'(state), 32'd1);

    // Disable wins over a simultaneous violation
    fetch(1'b1);
    check("virt_third", 32'(state), 32'd2);
    iorq_n = 1'b0; io_violation = 1'b1; virtual_enable = 1'b0;
    step();
    iorq_n = 1'b1; io_violation = 1'b0;
    check("dis_idle", 32'(state), 32'd0);
    check("dis_no_capture", 32'(capture_address), 32'd0);
    check("dis_nmi_n", 32'(nmi_n), 32'd1);
    check("dis_trap", 32'(trap_state), 32'd1);
    step();
    check("dis_no_capture2", 32'(capture_address), 32'd0);
    check("dis_nmi_n2", 32'(nmi_n), 32'd1);

    // Asynchronous reset in the middle of an NMI pulse
    virtual_enable = 1'b1;
    pulse_exit();
    fetch(1'b1);
    violate();
    step();
    check("pre_rst_nmi", 32'(nmi_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_nmi_n", 32'(nmi_n), 32'd1);
    check("arst_state", 32'(state), 32'd0);
    check("arst_trap", 32'(trap_state), 32'd1);
    check("arst_flag", 32'(violation_flag), 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
